// File: rtl/plab5_mcore_mem_bank_responder.sv
// Memory-side bank endpoint: services ring requests against a local word
// array and returns responses after a fixed service latency.
module plab5_mcore_mem_bank_responder #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_num_banks        = 4,
    parameter int p_num_words        = 256,
    parameter int p_latency          = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic [p_mem_opaque_nbits+p_mem_addr_nbits+p_mem_data_nbits+4:0] req_msg,
    input  logic req_val,
    output logic req_rdy,
    output logic [p_mem_opaque_nbits+p_mem_data_nbits+4:0] resp_msg,
    output logic resp_val,
    input  logic resp_rdy
);

    localparam int O  = p_mem_opaque_nbits;
    localparam int A  = p_mem_addr_nbits;
    localparam int D  = p_mem_data_nbits;
    localparam int BW = $clog2(p_num_banks);
    localparam int IW = $clog2(p_num_words);
    localparam int CW = $clog2(p_latency + 1);
    localparam logic [CW-1:0] LAT_M2 = CW'((p_latency >= 2) ? p_latency - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]    w_req_type;
    logic [O-1:0]  w_req_opq;
    logic [A-1:0]  w_req_addr;
    logic [1:0]    w_req_len;
    logic [D-1:0]  w_req_data;
    logic [IW-1:0] w_idx;
    logic [3:0]    w_bmask;
    logic [D-1:0]  w_mask;
    logic          w_accept;
    logic          w_is_wr;
    logic          w_is_rd;
    logic          w_unused;

    logic [2:0]    r_type;
    logic [O-1:0]  r_opq;
    logic [1:0]    r_len;
    logic [D-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    logic [D-1:0]  r_mem [p_num_words];

    assign {w_req_type, w_req_opq, w_req_addr, w_req_len, w_req_data} = req_msg;

    // Banks interleave at word granularity, so the bank-select bits sit
    // directly above the byte offset and are skipped for the local index.
    assign w_idx    = w_req_addr[2+BW +: IW];
    assign w_unused = ^w_req_addr;

    always_comb begin
        w_bmask = 4'hf;
        case (w_req_len)
            2'd1:    w_bmask = 4'h1;
            2'd2:    w_bmask = 4'h3;
            2'd3:    w_bmask = 4'h7;
            default: w_bmask = 4'hf;
        endcase
    end

    assign w_mask = {{8{w_bmask[3]}}, {8{w_bmask[2]}},
                     {8{w_bmask[1]}}, {8{w_bmask[0]}}};

    assign req_rdy  = (r_state == S_IDLE);
    assign resp_val = (r_state == S_RESP);
    assign w_accept = req_rdy && req_val;
    assign w_is_wr  = (w_req_type == 3'd1) || (w_req_type == 3'd2);
    assign w_is_rd  = (w_req_type == 3'd0);

    assign resp_msg = {r_type, r_opq, r_len, r_data};

    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_req_data & w_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type <= '0;
            r_opq  <= '0;
            r_len  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_type <= w_req_type;
            r_opq  <= w_req_opq;
            r_len  <= w_req_len;
            r_data <= w_is_rd ? (r_mem[w_idx] & w_mask) : '0;
            r_cnt  <= LAT_M2;
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_val) begin
                    w_state_next = (p_latency == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_rdy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
